// File: rtl/alu_shuffle_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu_shuffle_pkg                                                  |
// | Purpose : Shared constants and elaboration helpers for the zip/unzip       |
// |           (perfect-shuffle) ALU unit.                                      |
// | Contents: ILLEGAL_WORD  - fill pattern for results of an illegal funct     |
// |           MODE_ZIP/UNZIP- encodings of the mode input                      |
// |           clog2()       - constant ceiling log2                            |
// |           data_w_is_legal() - operand width legality check                 |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package alu_shuffle_pkg;

   localparam logic [31:0] ILLEGAL_WORD = 32'hDEADBEEF;
   localparam logic        MODE_ZIP     = 1'b0;
   localparam logic        MODE_UNZIP   = 1'b1;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   function automatic bit data_w_is_legal(input int w);
      return (w == 32) || (w == 64) || (w == 128) || (w == 256);
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_shuffle_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu_shuffle_core                                                 |
// | Purpose : Purely combinational zip/unzip of one operand at granularity     |
// |           G = 2^funct bits.                                                |
// | Ports   : din   [DATA_W-1:0]  operand                                      |
// |           funct [FUNCT_W-1:0] granularity select k                         |
// |           mode                0 = zip, 1 = unzip                           |
// |           res   [DATA_W-1:0]  shuffled result (fill pattern if illegal)    |
// |           err                 funct is not a legal granularity             |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module alu_shuffle_core
   import alu_shuffle_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int FUNCT_W = 3
) (
   input  logic [DATA_W-1:0]  din,
   input  logic [FUNCT_W-1:0] funct,
   input  logic               mode,
   output logic [DATA_W-1:0]  res,
   output logic               err
);

   localparam int LOG_W  = clog2(DATA_W);
   localparam int HALF_W = DATA_W / 2;

   if (!data_w_is_legal(DATA_W)) begin : g_bad_data_w
      $error("alu_shuffle_core: DATA_W must be 32, 64, 128 or 256");
   end
   if ((1 << FUNCT_W) <= LOG_W) begin : g_bad_funct_w
      $error("alu_shuffle_core: FUNCT_W too narrow to encode every granularity");
   end

   // One fully wired shuffle network per legal granularity; funct just picks one.
   logic [LOG_W-1:0][DATA_W-1:0] w_zip;
   logic [LOG_W-1:0][DATA_W-1:0] w_unzip;

   for (genvar k = 0; k < LOG_W; k++) begin : g_gran
      localparam int G  = 1 << k;
      localparam int NC = HALF_W / G;   // chunks per half
      for (genvar j = 0; j < NC; j++) begin : g_chunk
         // zip: low-half chunk j to even slot, high-half chunk j to odd slot
         assign w_zip[k][(2*j)*G +: G]       = din[j*G +: G];
         assign w_zip[k][(2*j+1)*G +: G]     = din[HALF_W + j*G +: G];
         // unzip: even slots gather into the low half, odd slots into the high half
         assign w_unzip[k][j*G +: G]          = din[(2*j)*G +: G];
         assign w_unzip[k][HALF_W + j*G +: G] = din[(2*j+1)*G +: G];
      end
   end

   always_comb begin
      res = {(DATA_W/32){ILLEGAL_WORD}};
      err = 1'b1;
      for (int k = 0; k < LOG_W; k++) begin
         if (32'(funct) == k) begin
            err = 1'b0;
            case (mode)
               MODE_ZIP:   res = w_zip[k];
               MODE_UNZIP: res = w_unzip[k];
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_shuffle_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu_shuffle_pipe                                                 |
// | Purpose : Two-stage valid/ready pipeline around alu_shuffle_core with a    |
// |           sideband tag, synchronous flush and illegal-funct error flag.    |
// | Ports   : clk, rst_n (async, active-low), flush (sync drop of in-flight)   |
// |           in_valid/in_ready, din, funct, mode, tag_in   - request side     |
// |           out_valid/out_ready, res, tag_out, err        - result side      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module alu_shuffle_pipe
   import alu_shuffle_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int FUNCT_W = 3,
   parameter int TAG_W   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  din,
   input  logic [FUNCT_W-1:0] funct,
   input  logic               mode,
   input  logic [TAG_W-1:0]   tag_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  res,
   output logic [TAG_W-1:0]   tag_out,
   output logic               err
);

   // Stage 1: captured request
   logic               s1_valid_q, s1_valid_d;
   logic [DATA_W-1:0]  s1_din_q,   s1_din_d;
   logic [FUNCT_W-1:0] s1_funct_q, s1_funct_d;
   logic               s1_mode_q,  s1_mode_d;
   logic [TAG_W-1:0]   s1_tag_q,   s1_tag_d;

   // Stage 2: registered result
   logic               s2_valid_q, s2_valid_d;
   logic [DATA_W-1:0]  s2_res_q,   s2_res_d;
   logic               s2_err_q,   s2_err_d;
   logic [TAG_W-1:0]   s2_tag_q,   s2_tag_d;

   logic               w_s1_adv;
   logic               w_s2_adv;
   logic [DATA_W-1:0]  w_core_res;
   logic               w_core_err;

   alu_shuffle_core #(
      .DATA_W  (DATA_W),
      .FUNCT_W (FUNCT_W)
   ) u_core (
      .din   (s1_din_q),
      .funct (s1_funct_q),
      .mode  (s1_mode_q),
      .res   (w_core_res),
      .err   (w_core_err)
   );

   // out_ready is the only combinational input to in_ready.
   assign w_s2_adv = !s2_valid_q || out_ready;
   assign w_s1_adv = !s1_valid_q || w_s2_adv;
   assign in_ready = w_s1_adv;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_din_d   = s1_din_q;
      s1_funct_d = s1_funct_q;
      s1_mode_d  = s1_mode_q;
      s1_tag_d   = s1_tag_q;
      s2_valid_d = s2_valid_q;
      s2_res_d   = s2_res_q;
      s2_err_d   = s2_err_q;
      s2_tag_d   = s2_tag_q;

      if (w_s1_adv) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_din_d   = din;
            s1_funct_d = funct;
            s1_mode_d  = mode;
            s1_tag_d   = tag_in;
         end
      end

      if (w_s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_res_d = w_core_res;
            s2_err_d = w_core_err;
            s2_tag_d = s1_tag_q;
         end
      end

      // Flush wins over everything, including a request presented this cycle.
      if (flush) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_din_q   <= '0;
         s1_funct_q <= '0;
         s1_mode_q  <= 1'b0;
         s1_tag_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_res_q   <= '0;
         s2_err_q   <= 1'b0;
         s2_tag_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_din_q   <= s1_din_d;
         s1_funct_q <= s1_funct_d;
         s1_mode_q  <= s1_mode_d;
         s1_tag_q   <= s1_tag_d;
         s2_valid_q <= s2_valid_d;
         s2_res_q   <= s2_res_d;
         s2_err_q   <= s2_err_d;
         s2_tag_q   <= s2_tag_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign res       = s2_res_q;
   assign tag_out   = s2_tag_q;
   assign err       = s2_err_q;

endmodule
`default_nettype wire

// File: doc/alu_shuffle_pipe.md
Name: alu_shuffle_pipe

Overview:
- Pipelined, width-parametrised zip/unzip (perfect-shuffle) unit for the advanced ALU.
- Funct selects the interleave granularity G = 2^funct bits. Mode selects zip (interleave the two halves) or unzip (de-interleave).
- Adds valid/ready handshakes, a pass-through tag, a synchronous flush and an illegal-funct error flag.
- Sits between the ALU operand issue stage and the result writeback arbiter.

Parameters:
- DATA_W, 32: operand width; legal values 32, 64, 128, 256.
- FUNCT_W, 3: funct field width; must satisfy 2^FUNCT_W > log2(DATA_W).
- TAG_W, 4: sideband tag width; carried unchanged with each operation.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous; drops all in-flight operations
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request this cycle
- din  in  DATA_W  operand
- funct  in  FUNCT_W  granularity select k, G = 2^k
- mode  in  1  0 = zip, 1 = unzip
- tag_in  in  TAG_W  request tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- res  out  DATA_W  result
- tag_out  out  TAG_W  tag of the result
- err  out  1  result came from an illegal funct

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n). Reset clears both stage valids, so out_valid = 0, res = 0, tag_out = 0, err = 0 and in_ready = 1 after reset release.
- Resetting mid-operation discards all data.
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Pipeline:
  - S1 registers din, funct, mode and tag.
  - S2 registers the shuffled result, err and tag.
  - Latency is 2 cycles from input transfer to out_valid, with full throughput of 1 per cycle.
- Stall rules:
  - S2 advances when !s2_valid || out_ready.
  - S1 advances when !s1_valid || S2 advances.
  - in_ready = S1 advances. in_ready is combinational from out_ready; there is no other combinational path.
  - Stalled stages hold their contents.
  - res, tag_out and err are stable while out_valid && !out_ready.
- Operation, with N = DATA_W/2 and legal k < log2(DATA_W):
  - Zip: split din into lo = din[N-1:0] and hi = din[DATA_W-1:N], each made of N/G chunks. res chunk 2j = lo chunk j; res chunk 2j+1 = hi chunk j.
  - Unzip: the exact inverse. res lo chunk j = din chunk 2j; res hi chunk j = din chunk 2j+1.
  - k = log2(DATA_W)-1 is the identity in both modes.
  - k = 0 covers the full width. Upper bits are no longer zeroed.
- Illegal funct (k >= log2(DATA_W)): res = 32'hDEADBEEF replicated DATA_W/32 times, err = 1. The operation still flows through the pipeline and handshake normally.
- Flush:
  - Clears s1_valid and s2_valid on the next edge, regardless of out_ready.
  - An input presented in the flush cycle is dropped, even if in_ready is high.
  - out_valid is 0 in the cycle after flush.
- Ordering is strictly in-order. No result is dropped or duplicated under any backpressure pattern.

Decomposition:
- Package alu_shuffle_pkg holds:
  - ILLEGAL_WORD = 32'hDEADBEEF
  - MODE_ZIP = 0, MODE_UNZIP = 1
  - a constant function clog2
  - the legal-DATA_W check, used as an elaboration-time assertion
- Sub-module alu_shuffle_core: purely combinational, parametrised by DATA_W and FUNCT_W. Inputs din, funct, mode; outputs res, err. It is a generate/loop over chunk index and granularity.
- alu_shuffle_pipe wraps alu_shuffle_core with the two-stage valid/ready pipeline and the flush logic.

Test Plan:
- DATA_W=32, din=0x0000FFFF, funct=0, mode=0 -> res=0x55555555, err=0, out_valid exactly 2 cycles after acceptance. Then din=0x55555555, mode=1 -> res=0x0000FFFF.
- DATA_W=32, din=0x33221100, funct=3: mode=0 -> 0x33112200; mode=1 -> 0x33112200; funct=4, either mode -> 0x33221100. funct=2, mode=0, din=0x0000FFFF -> 0x0F0F0F0F.
- DATA_W=32, funct=5 and funct=7, any din -> res=0xDEADBEEF, err=1. DATA_W=64, funct=6 -> res=0xDEADBEEFDEADBEEF, err=1; funct=5 -> identity, err=0.
- Backpressure: stream 6 ops with tags 0..5 while out_ready is low for cycles 2–6. in_ready falls after 2 ops are held. Outputs then appear in tag order 0..5 with correct results and no loss or duplication; res is stable during the stall.
- Flush: with both stages full and out_ready=0, assert flush together with in_valid. out_valid=0 next cycle, the flushed and concurrent inputs never appear, and the next request produces the correct result 2 cycles later.
- Async reset: drop rst_n mid-stream between clock edges. Outputs clear immediately to 0 and in_ready=1 after release; no stale result emerges.
